// File: rtl/chipinvaders_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chipinvaders_pkg
//  Description : Shared screen constants, march direction type and the
//                fleet/laser cell-geometry test used by both the pixel
//                renderer and the laser hit detector.
//  Revision    : 1.0  initial release
// ============================================================================
package chipinvaders_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int POS_W    = 10;

    typedef enum logic [0:0] {
        MOVE_RIGHT = 1'b0,
        MOVE_LEFT  = 1'b1
    } dir_e;

    // Result of locating a point inside the formation grid. row/col are only
    // meaningful when hit is set.
    typedef struct packed {
        logic             hit;
        logic [POS_W-1:0] row;
        logic [POS_W-1:0] col;
    } geom_t;

    // A point hits a cell when it lies at or beyond the fleet origin, inside
    // the grid, and inside the sprite box at the top-left of its cell.
    // All comparisons are unsigned; a point left of / above the origin is a
    // miss rather than a wrapped-around coordinate.
    function automatic geom_t fleet_geom(
        input logic [POS_W-1:0] px,
        input logic [POS_W-1:0] py,
        input logic [POS_W-1:0] fx,
        input logic [POS_W-1:0] fy,
        input int               cw_log2,
        input int               ch_log2,
        input logic [POS_W-1:0] cols,
        input logic [POS_W-1:0] rows,
        input logic [POS_W-1:0] sw,
        input logic [POS_W-1:0] sh
    );
        logic [POS_W-1:0] dx;
        logic [POS_W-1:0] dy;
        logic [POS_W-1:0] mx;
        logic [POS_W-1:0] my;
        geom_t            g;
        dx    = px - fx;
        dy    = py - fy;
        mx    = POS_W'((1 << cw_log2) - 1);
        my    = POS_W'((1 << ch_log2) - 1);
        g.col = dx >> cw_log2;
        g.row = dy >> ch_log2;
        g.hit = (px >= fx) && (py >= fy) && (g.col < cols) && (g.row < rows) &&
                ((dx & mx) < sw) && ((dy & my) < sh);
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alien_hit_detect.sv
`default_nettype none
// ============================================================================
//  Module      : alien_hit_detect
//  Description : Two-stage laser-versus-fleet hit pipeline.
//                Stage A (tick+1): registers candidate hit and its row/col,
//                using the fleet origin from before this frame's march.
//                Stage B (tick+2): confirms against the alive bitmap and
//                strobes a kill (at most one per frame).
//  Ports       : clk, rst_n           clock, async active-low reset
//                restart              sync re-arm, overrides a kill
//                tick, enable         frame tick, not-frozen qualifier
//                laser_*              laser state
//                fleet_x/y, alive     formation state
//                kill, kill_row/col   combinational kill request to owner
//                hit_alien, hit_pulse registered laser feedback / score strobe
//  Revision    : 1.0  initial release
// ============================================================================
module alien_hit_detect
    import chipinvaders_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int COLS        = 8,
    parameter int ROW_W       = 2,
    parameter int COL_W       = 3,
    parameter int CELL_W_LOG2 = 5,
    parameter int CELL_H_LOG2 = 4,
    parameter int SPRITE_W    = 16,
    parameter int SPRITE_H    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       restart,
    input  logic                       tick,
    input  logic                       enable,
    input  logic                       laser_active,
    input  logic [POS_W-1:0]           laser_x,
    input  logic [POS_W-1:0]           laser_y,
    input  logic [POS_W-1:0]           fleet_x,
    input  logic [POS_W-1:0]           fleet_y,
    input  logic [ROWS-1:0][COLS-1:0]  alive,
    output logic                       kill,
    output logic [ROW_W-1:0]           kill_row,
    output logic [COL_W-1:0]           kill_col,
    output logic                       hit_alien,
    output logic                       hit_pulse
);

    geom_t            laser_geom;
    logic             geom_unused;
    logic             cand_q,      cand_d;
    logic [ROW_W-1:0] row_q,       row_d;
    logic [COL_W-1:0] col_q,       col_d;
    logic             hit_alien_q, hit_alien_d;
    logic             hit_pulse_q, hit_pulse_d;

    always_comb begin
        laser_geom = fleet_geom(laser_x, laser_y, fleet_x, fleet_y,
                                CELL_W_LOG2, CELL_H_LOG2,
                                POS_W'(COLS), POS_W'(ROWS),
                                POS_W'(SPRITE_W), POS_W'(SPRITE_H));
    end

    // Upper row/col bits are zero whenever hit is set.
    assign geom_unused = ^{laser_geom.row[POS_W-1:ROW_W], laser_geom.col[POS_W-1:COL_W]};

    // A candidate lives for exactly one cycle, so stage B can fire only once
    // per tick.
    assign kill = cand_q && enable && !restart && alive[row_q][col_q];

    always_comb begin
        cand_d      = tick && enable && !restart && laser_active && laser_geom.hit;
        row_d       = row_q;
        col_d       = col_q;
        if (tick) begin
            row_d = laser_geom.row[ROW_W-1:0];
            col_d = laser_geom.col[COL_W-1:0];
        end
        hit_pulse_d = kill;
        hit_alien_d = hit_alien_q;
        if (tick)    hit_alien_d = 1'b0;
        if (kill)    hit_alien_d = 1'b1;
        if (restart) hit_alien_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q      <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            hit_alien_q <= 1'b0;
            hit_pulse_q <= 1'b0;
        end else begin
            cand_q      <= cand_d;
            row_q       <= row_d;
            col_q       <= col_d;
            hit_alien_q <= hit_alien_d;
            hit_pulse_q <= hit_pulse_d;
        end
    end

    assign kill_row  = row_q;
    assign kill_col  = col_q;
    assign hit_alien = hit_alien_q;
    assign hit_pulse = hit_pulse_q;

endmodule
`default_nettype wire

// File: rtl/alien_fleet.sv
`default_nettype none
// ============================================================================
//  Module      : alien_fleet
//  Description : Alien formation owner: alive bitmap, marching origin,
//                per-pixel graphics and laser hit response.
//  Ports       : clk, rst_n               pixel clock, async active-low reset
//                vsync                    rising edge = frame tick
//                hpos, vpos               current pixel
//                laser_active/x/y         laser state
//                restart                  sync re-arm pulse
//                alien_gfx                pixel is a live alien (combinational)
//                hit_alien, hit_pulse     laser feedback / one-cycle kill strobe
//                alive_count, all_dead    remaining aliens
//                reached_bottom           sticky game-over
//  Revision    : 1.0  initial release
// ============================================================================
module alien_fleet
    import chipinvaders_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int COLS        = 8,
    parameter int CELL_W_LOG2 = 5,
    parameter int CELL_H_LOG2 = 4,
    parameter int SPRITE_W    = 16,
    parameter int SPRITE_H    = 8,
    parameter int START_X     = 64,
    parameter int START_Y     = 48,
    parameter int STEP_X      = 4,
    parameter int STEP_Y      = 8,
    parameter int MARCH_DIV   = 30,
    parameter int LEFT_BOUND  = 8,
    parameter int RIGHT_BOUND = 632,
    parameter int BOTTOM_Y    = 424
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              vsync,
    input  logic [9:0]                        hpos,
    input  logic [9:0]                        vpos,
    input  logic                              laser_active,
    input  logic [9:0]                        laser_x,
    input  logic [9:0]                        laser_y,
    input  logic                              restart,
    output logic                              alien_gfx,
    output logic                              hit_alien,
    output logic                              hit_pulse,
    output logic [$clog2(ROWS*COLS+1)-1:0]    alive_count,
    output logic                              all_dead,
    output logic                              reached_bottom
);

    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ALIVE_W = $clog2(ROWS*COLS+1);
    localparam int FRAME_W = (MARCH_DIV > 1) ? $clog2(MARCH_DIV) : 1;

    localparam logic [FRAME_W-1:0] c_frame_last = FRAME_W'(MARCH_DIV - 1);
    // Edge tests rearranged so no sum can overflow the position width.
    localparam logic [POS_W-1:0]   c_right_lim  = POS_W'(RIGHT_BOUND - (COLS << CELL_W_LOG2) - STEP_X);
    localparam logic [POS_W-1:0]   c_left_lim   = POS_W'(LEFT_BOUND + STEP_X);
    localparam logic [POS_W-1:0]   c_bottom_lim = POS_W'(BOTTOM_Y - (ROWS << CELL_H_LOG2));

    logic                      vsync_q,          vsync_d;
    logic                      tick_q,           tick_d;
    logic [POS_W-1:0]          fleet_x_q,        fleet_x_d;
    logic [POS_W-1:0]          fleet_y_q,        fleet_y_d;
    dir_e                      dir_q,            dir_d;
    logic [FRAME_W-1:0]        frame_cnt_q,      frame_cnt_d;
    logic [ROWS-1:0][COLS-1:0] alive_q,          alive_d;
    logic [ALIVE_W-1:0]        alive_count_q,    alive_count_d;
    logic                      reached_bottom_q, reached_bottom_d;

    logic                      step;
    logic                      frozen;
    logic                      kill;
    logic [ROW_W-1:0]          kill_row;
    logic [COL_W-1:0]          kill_col;
    geom_t                     gfx_geom;
    logic                      geom_unused;

    assign all_dead = (alive_count_q == '0);
    assign frozen   = all_dead || reached_bottom_q;

    alien_hit_detect #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .ROW_W       (ROW_W),
        .COL_W       (COL_W),
        .CELL_W_LOG2 (CELL_W_LOG2),
        .CELL_H_LOG2 (CELL_H_LOG2),
        .SPRITE_W    (SPRITE_W),
        .SPRITE_H    (SPRITE_H)
    ) u_hit_detect (
        .clk          (clk),
        .rst_n        (rst_n),
        .restart      (restart),
        .tick         (tick_q),
        .enable       (!frozen),
        .laser_active (laser_active),
        .laser_x      (laser_x),
        .laser_y      (laser_y),
        .fleet_x      (fleet_x_q),
        .fleet_y      (fleet_y_q),
        .alive        (alive_q),
        .kill         (kill),
        .kill_row     (kill_row),
        .kill_col     (kill_col),
        .hit_alien    (hit_alien),
        .hit_pulse    (hit_pulse)
    );

    always_comb begin
        gfx_geom  = fleet_geom(hpos, vpos, fleet_x_q, fleet_y_q,
                               CELL_W_LOG2, CELL_H_LOG2,
                               POS_W'(COLS), POS_W'(ROWS),
                               POS_W'(SPRITE_W), POS_W'(SPRITE_H));
        alien_gfx = gfx_geom.hit &&
                    alive_q[gfx_geom.row[ROW_W-1:0]][gfx_geom.col[COL_W-1:0]];
    end

    assign geom_unused = ^{gfx_geom.row[POS_W-1:ROW_W], gfx_geom.col[POS_W-1:COL_W]};

    always_comb begin
        vsync_d          = vsync;
        tick_d           = vsync && !vsync_q;
        fleet_x_d        = fleet_x_q;
        fleet_y_d        = fleet_y_q;
        dir_d            = dir_q;
        frame_cnt_d      = frame_cnt_q;
        alive_d          = alive_q;
        alive_count_d    = alive_count_q;
        reached_bottom_d = reached_bottom_q;
        step             = 1'b0;

        if (tick_q && !frozen) begin
            if (frame_cnt_q == c_frame_last) begin
                frame_cnt_d = '0;
                step        = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + FRAME_W'(1);
            end
        end

        if (step) begin
            case (dir_q)
                MOVE_RIGHT: begin
                    if (fleet_x_q > c_right_lim) begin
                        fleet_y_d = fleet_y_q + POS_W'(STEP_Y);
                        dir_d     = MOVE_LEFT;
                    end else begin
                        fleet_x_d = fleet_x_q + POS_W'(STEP_X);
                    end
                end
                MOVE_LEFT: begin
                    if (fleet_x_q < c_left_lim) begin
                        fleet_y_d = fleet_y_q + POS_W'(STEP_Y);
                        dir_d     = MOVE_RIGHT;
                    end else begin
                        fleet_x_d = fleet_x_q - POS_W'(STEP_X);
                    end
                end
                default: dir_d = MOVE_RIGHT;
            endcase
            if (fleet_y_d >= c_bottom_lim) begin
                reached_bottom_d = 1'b1;
            end
        end

        if (kill) begin
            alive_d[kill_row][kill_col] = 1'b0;
            alive_count_d               = alive_count_q - ALIVE_W'(1);
        end

        // Re-arm takes priority over any step or kill landing this cycle.
        if (restart) begin
            fleet_x_d        = POS_W'(START_X);
            fleet_y_d        = POS_W'(START_Y);
            dir_d            = MOVE_RIGHT;
            frame_cnt_d      = '0;
            alive_d          = '1;
            alive_count_d    = ALIVE_W'(ROWS*COLS);
            reached_bottom_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q          <= 1'b0;
            tick_q           <= 1'b0;
            fleet_x_q        <= POS_W'(START_X);
            fleet_y_q        <= POS_W'(START_Y);
            dir_q            <= MOVE_RIGHT;
            frame_cnt_q      <= '0;
            alive_q          <= '1;
            alive_count_q    <= ALIVE_W'(ROWS*COLS);
            reached_bottom_q <= 1'b0;
        end else begin
            vsync_q          <= vsync_d;
            tick_q           <= tick_d;
            fleet_x_q        <= fleet_x_d;
            fleet_y_q        <= fleet_y_d;
            dir_q            <= dir_d;
            frame_cnt_q      <= frame_cnt_d;
            alive_q          <= alive_d;
            alive_count_q    <= alive_count_d;
            reached_bottom_q <= reached_bottom_d;
        end
    end

    assign alive_count    = alive_count_q;
    assign reached_bottom = reached_bottom_q;

endmodule
`default_nettype wire

// File: tb/tb_alien_fleet.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alien_fleet
//  Description : Directed self-checking bench for alien_fleet.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alien_fleet;
    import chipinvaders_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       vsync;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       laser_active;
    logic [9:0] laser_x;
    logic [9:0] laser_y;
    logic       restart;
    logic       alien_gfx;
    logic       hit_alien;
    logic       hit_pulse;
    logic [5:0] alive_count;
    logic       all_dead;
    logic       reached_bottom;

    int         checks;
    int         errors;
    int         pix;
    logic [2:0] hp;
    logic [2:0] ha;

    alien_fleet dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .vsync          (vsync),
        .hpos           (hpos),
        .vpos           (vpos),
        .laser_active   (laser_active),
        .laser_x        (laser_x),
        .laser_y        (laser_y),
        .restart        (restart),
        .alien_gfx      (alien_gfx),
        .hit_alien      (hit_alien),
        .hit_pulse      (hit_pulse),
        .alive_count    (alive_count),
        .all_dead       (all_dead),
        .reached_bottom (reached_bottom)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // One frame: vsync rises at N0. hp/ha sample after the tick edge, tick+1
    // and tick+2 edges respectively.
    task automatic run_frame(output logic [2:0] p, output logic [2:0] a);
        @(negedge clk); vsync = 1'b1;
        @(negedge clk); p[0] = hit_pulse; a[0] = hit_alien;
        @(negedge clk); p[1] = hit_pulse; a[1] = hit_alien; vsync = 1'b0;
        @(negedge clk); p[2] = hit_pulse; a[2] = hit_alien;
        @(negedge clk);
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) run_frame(hp, ha);
    endtask

    task automatic pulse_restart();
        @(negedge clk); restart = 1'b1;
        @(negedge clk); restart = 1'b0;
    endtask

    task automatic gfx_probe(input string tag, input int x, input int y, input logic exp);
        hpos = 10'(x);
        vpos = 10'(y);
        #1;
        check_eq(tag, alien_gfx, exp);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; vsync = 1'b0; hpos = '0; vpos = '0;
        laser_active = 1'b0; laser_x = '0; laser_y = '0; restart = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_alive_count", alive_count, 32);
        check_eq("rst_all_dead", all_dead, 0);
        check_eq("rst_hit_alien", hit_alien, 0);
        check_eq("rst_hit_pulse", hit_pulse, 0);
        check_eq("rst_bottom", reached_bottom, 0);
        check_eq("rst_fleet_x", dut.fleet_x_q, 64);
        check_eq("rst_fleet_y", dut.fleet_y_q, 48);
        rst_n = 1'b1;
        @(negedge clk);

        // Graphics: corner pixels and the total lit area of a full fleet.
        gfx_probe("gfx_64_48", 64, 48, 1'b1);
        gfx_probe("gfx_79_55", 79, 55, 1'b1);
        gfx_probe("gfx_80_48", 80, 48, 1'b0);
        gfx_probe("gfx_64_56", 64, 56, 1'b0);
        gfx_probe("gfx_63_48", 63, 48, 1'b0);
        pix = 0;
        for (int y = 40; y < 120; y++) begin
            for (int x = 56; x < 336; x++) begin
                hpos = 10'(x);
                vpos = 10'(y);
                #1;
                if (alien_gfx) pix++;
            end
        end
        check_eq("gfx_count", pix, 32*16*8);

        // Kill alien [0][0].
        laser_x = 10'd70; laser_y = 10'd50; laser_active = 1'b1;
        run_frame(hp, ha);
        check_eq("kill_pulse_timing", hp, 3'b100);
        check_eq("kill_hit_alien_set", ha, 3'b100);
        check_eq("kill_alive_00", dut.alive_q[0][0], 0);
        check_eq("kill_count", alive_count, 31);
        gfx_probe("gfx_dead_alien", 64, 48, 1'b0);

        // Same point again: dead alien, so a miss; hit_alien drops at the tick.
        run_frame(hp, ha);
        check_eq("repeat_miss_pulse", hp, 3'b000);
        check_eq("hit_alien_clear", ha, 3'b001);
        check_eq("repeat_count", alive_count, 31);

        laser_x = 10'd80; laser_y = 10'd50;
        run_frame(hp, ha);
        check_eq("gap_miss", hp, 3'b000);
        laser_x = 10'd63;
        run_frame(hp, ha);
        check_eq("left_miss", hp, 3'b000);
        laser_x = 10'd72; laser_active = 1'b0;
        run_frame(hp, ha);
        check_eq("inactive_miss", hp, 3'b000);
        check_eq("alive_after_misses", dut.alive_q, 32'hFFFF_FFFE);

        // March from a clean restart.
        pulse_restart();
        check_eq("restart_count", alive_count, 32);
        check_eq("restart_alive", dut.alive_q, 32'hFFFF_FFFF);
        run_frames(29);
        check_eq("no_step_29", dut.fleet_x_q, 64);
        run_frames(1);
        check_eq("step_30", dut.fleet_x_q, 68);
        run_frames(30*77);
        check_eq("march_right_x", dut.fleet_x_q, 376);
        check_eq("march_right_y", dut.fleet_y_q, 48);
        check_eq("march_dir_r", 32'(dut.dir_q), 32'(MOVE_RIGHT));
        run_frames(30);
        check_eq("descend_x", dut.fleet_x_q, 376);
        check_eq("descend_y", dut.fleet_y_q, 56);
        check_eq("descend_dir", 32'(dut.dir_q), 32'(MOVE_LEFT));
        run_frames(30);
        check_eq("march_left_x", dut.fleet_x_q, 372);
        check_eq("march_left_y", dut.fleet_y_q, 56);

        // Jump the fleet near the left edge and floor, then let one step land.
        @(negedge clk);
        force dut.fleet_x_q = 10'd8;
        force dut.fleet_y_q = 10'd352;
        @(negedge clk);
        release dut.fleet_x_q;
        release dut.fleet_y_q;
        check_eq("bottom_not_yet", reached_bottom, 0);
        for (int i = 0; i < 40 && !reached_bottom; i++) run_frame(hp, ha);
        check_eq("bottom_latched", reached_bottom, 1);
        check_eq("bottom_y", dut.fleet_y_q, 360);
        check_eq("bottom_x", dut.fleet_x_q, 8);
        run_frames(31);
        check_eq("frozen_x", dut.fleet_x_q, 8);
        check_eq("frozen_y", dut.fleet_y_q, 360);
        check_eq("bottom_sticky", reached_bottom, 1);

        pulse_restart();
        check_eq("rs_bottom", reached_bottom, 0);
        check_eq("rs_x", dut.fleet_x_q, 64);
        check_eq("rs_y", dut.fleet_y_q, 48);
        check_eq("rs_dir", 32'(dut.dir_q), 32'(MOVE_RIGHT));
        check_eq("rs_count", alive_count, 32);

        // Restart on the same edge the kill would register.
        laser_x = 10'd70; laser_y = 10'd50; laser_active = 1'b1;
        @(negedge clk); vsync = 1'b1;
        @(negedge clk);
        @(negedge clk); vsync = 1'b0; restart = 1'b1;
        @(negedge clk); restart = 1'b0;
        check_eq("rk_pulse", hit_pulse, 0);
        check_eq("rk_alive", dut.alive_q, 32'hFFFF_FFFF);
        check_eq("rk_count", alive_count, 32);
        check_eq("rk_hit_alien", hit_alien, 0);

        // Real kill, then asynchronous reset between clock edges.
        run_frame(hp, ha);
        check_eq("pre_rst_count", alive_count, 31);
        check_eq("pre_rst_hit_alien", hit_alien, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_count", alive_count, 32);
        check_eq("arst_hit_alien", hit_alien, 0);
        check_eq("arst_hit_pulse", hit_pulse, 0);
        check_eq("arst_all_dead", all_dead, 0);
        check_eq("arst_bottom", reached_bottom, 0);
        check_eq("arst_x", dut.fleet_x_q, 64);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
